axilite_regbank_slave: RTL and testbench
========================================

# axilite_regbank_slave

AXI4-Lite register-bank slave placed directly downstream of `wb_to_axilite_bridge`. It terminates the bridge's `M_AXI_*` master port in `NUM_REGS` 32-bit read/write registers with byte-strobe writes. Each transaction gets exactly one response. Out-of-range and multi-beat accesses are absorbed safely with SLVERR. The register contents are exported to fabric as a flat vector.

## Interface
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width; only 32 is supported.
- `ID_WIDTH`, 4: AXI ID width.
- `NUM_REGS`, 16: register count, 2..256.
- `BASE_ADDR`, 32'h0000_1000: byte address of register 0.
- `ID_VALUE`, 32'hA5A5_0001: read-only ID word; used only when the Configuration macro is defined.

Ports:
- `ACLK`  in  1  clock.
- `ARESET`  in  1  asynchronous, active-high reset.
- `S_AXI_awid`  in  ID_WIDTH  write ID.
- `S_AXI_awaddr`  in  ADDR_WIDTH  write address.
- `S_AXI_awlen`  in  8  write beats minus 1.
- `S_AXI_aw{size,burst,lock,cache,prot,qos,region}`  in  as AXI4  accepted and ignored.
- `S_AXI_awvalid` / `S_AXI_awready`  in/out  1  AW handshake.
- `S_AXI_wdata`  in  DATA_WIDTH  write data.
- `S_AXI_wstrb`  in  DATA_WIDTH/8  byte enables.
- `S_AXI_wlast`  in  1  last write beat.
- `S_AXI_wvalid` / `S_AXI_wready`  in/out  1  W handshake.
- `S_AXI_bid`  out  ID_WIDTH  echoes the captured awid.
- `S_AXI_bresp`  out  2  OKAY=00, SLVERR=10.
- `S_AXI_bvalid` / `S_AXI_bready`  out/in  1  B handshake.
- `S_AXI_arid`, `S_AXI_araddr`, `S_AXI_arlen`, `S_AXI_ar{size,burst,lock,cache,prot,qos,region}`  in  as AW channel  read request.
- `S_AXI_arvalid` / `S_AXI_arready`  in/out  1  AR handshake.
- `S_AXI_rid`  out  ID_WIDTH  echoes the captured arid.
- `S_AXI_rdata`  out  DATA_WIDTH  read data.
- `S_AXI_rresp`  out  2  read response.
- `S_AXI_rlast`  out  1  last read beat.
- `S_AXI_rvalid` / `S_AXI_rready`  out/in  1  R handshake.
- `regs_o`  out  NUM_REGS*32  register contents; register *i* occupies bits [32i+31:32i].

## Operation
**Address decode**
- `off = addr - BASE_ADDR`. A hit requires `addr >= BASE_ADDR` and `off < NUM_REGS*4`.
- Register index is `off[..:2]`; `addr[1:0]` is ignored.
- A miss or `len != 0` yields SLVERR.

**Write FSM: W_IDLE → W_DATA → W_RESP**
- W_IDLE: `awready` and `wready` are each high until their own beat is captured. AW and W may arrive in either order or in the same cycle. Captured fields: id, addr, len, data, strb, last.
- Once both are held with `len == 0`:
  - On a hit, each byte with `strb[k]=1` is written.
  - The FSM goes to W_RESP.
- If `len != 0`, the FSM goes to W_DATA.
  - `wready=1` stays high and beats are discarded until the `wlast` beat.
  - No register is modified.
  - The FSM then goes to W_RESP with SLVERR.
- A W beat arriving first with `wlast=0` is treated the same way: beats are drained until `wlast`.
- W_RESP: `bvalid=1` holding the captured `bid` and `bresp` until `bready`, then back to W_IDLE. `awready` and `wready` are 0 in this state.

**Read FSM: R_IDLE → R_DATA**
- R_IDLE: `arready=1`. The AR handshake captures id, addr and len.
- R_DATA: beats = len+1, using a down-counter.
  - Hit with `len == 0`: `rdata` is the register value, `rresp` is OKAY.
  - Otherwise every beat has `rdata=0` and `rresp=SLVERR`.
  - `rlast=1` only on the final beat.
  - Each beat holds until `rready`; after the final handshake the FSM returns to R_IDLE.

**Concurrency**
- The read and write FSMs are independent.
- A read data beat is registered when R_DATA is entered, or after the previous beat's handshake. A write committing on the same edge is not visible in that beat.

## Timing
- All outputs reset to 0, including `regs_o`. Both FSMs reset to IDLE. Reset mid-transaction abandons it with no response.
- Write: last of AW/W handshaked at edge N → `bvalid=1` from edge N; register updated at edge N, visible on `regs_o` after N.
- Back-to-back writes: after B handshake at edge M, `awready`/`wready` high from edge M; minimum 2 cycles per write.
- Read: AR handshake at edge N → `rvalid=1`, valid data from edge N; with `rready` held high, one beat per cycle.
- `rvalid`/`bvalid` never drop without handshake; payload stable while stalled.

## Configuration
- `AXIL_REGBANK_ID_REG_EN` defined: register `NUM_REGS-1` is read-only.
  - Reads return `ID_VALUE`.
  - Writes are ignored but respond OKAY.
  - Its `regs_o` slice equals `ID_VALUE`.
- Undefined: all `NUM_REGS` registers are read/write.

## Test plan
- Write 0xCAFEBABE to 0x1004 (`wstrb=F`, `awready`/`wready` observed, `bready=1`) → `bresp=00`, `bid` equals `awid`=3; read 0x1004 → `rdata=0xCAFEBABE`, `rresp=00`, `rlast=1`.
- W presented 2 cycles before AW; then partial write `wstrb=4'b0101` of 0x11223344 over 0xCAFEBABE → reads 0xCA22BA44.
- Write to 0x2000 (miss) → `bresp=10`, no `regs_o` change; read 0x0FFC → `rresp=10`, `rdata=0`.
- Read burst `arlen=3` → 4 beats with SLVERR, `rlast` on beat 4 only; write `awlen=1` → both beats accepted, single B with SLVERR.
- Hold `bready=0` and `rready=0` for 5 cycles with concurrent write and read → `bvalid`/`rvalid` and payloads stable; assert ARESET mid-read → all outputs 0 next cycle, registers cleared.
- With `AXIL_REGBANK_ID_REG_EN`: write 0x0 to 0x103C → `bresp=00`, read 0x103C returns 0xA5A50001.

Source files
------------

// File: rtl/axilite_regbank_slave.sv
// AXI4-Lite register bank: NUM_REGS x 32-bit byte-strobed registers behind an AXI4 slave port.
// Define AXIL_REGBANK_ID_REG_EN to make the top register a read-only ID word (ID_VALUE).
module axilite_regbank_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_1000,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA5A5_0001
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [ID_WIDTH-1:0]       S_AXI_awid,
  input  logic [ADDR_WIDTH-1:0]     S_AXI_awaddr,
  input  logic [7:0]                S_AXI_awlen,
  input  logic [2:0]                S_AXI_awsize,
  input  logic [1:0]                S_AXI_awburst,
  input  logic                      S_AXI_awlock,
  input  logic [3:0]                S_AXI_awcache,
  input  logic [2:0]                S_AXI_awprot,
  input  logic [3:0]                S_AXI_awqos,
  input  logic [3:0]                S_AXI_awregion,
  input  logic                      S_AXI_awvalid,
  output logic                      S_AXI_awready,
  input  logic [DATA_WIDTH-1:0]     S_AXI_wdata,
  input  logic [DATA_WIDTH/8-1:0]   S_AXI_wstrb,
  input  logic                      S_AXI_wlast,
  input  logic                      S_AXI_wvalid,
  output logic                      S_AXI_wready,
  output logic [ID_WIDTH-1:0]       S_AXI_bid,
  output logic [1:0]                S_AXI_bresp,
  output logic                      S_AXI_bvalid,
  input  logic                      S_AXI_bready,
  input  logic [ID_WIDTH-1:0]       S_AXI_arid,
  input  logic [ADDR_WIDTH-1:0]     S_AXI_araddr,
  input  logic [7:0]                S_AXI_arlen,
  input  logic [2:0]                S_AXI_arsize,
  input  logic [1:0]                S_AXI_arburst,
  input  logic                      S_AXI_arlock,
  input  logic [3:0]                S_AXI_arcache,
  input  logic [2:0]                S_AXI_arprot,
  input  logic [3:0]                S_AXI_arqos,
  input  logic [3:0]                S_AXI_arregion,
  input  logic                      S_AXI_arvalid,
  output logic                      S_AXI_arready,
  output logic [ID_WIDTH-1:0]       S_AXI_rid,
  output logic [DATA_WIDTH-1:0]     S_AXI_rdata,
  output logic [1:0]                S_AXI_rresp,
  output logic                      S_AXI_rlast,
  output logic                      S_AXI_rvalid,
  input  logic                      S_AXI_rready,
  output logic [NUM_REGS*32-1:0]    regs_o
);

`ifdef AXIL_REGBANK_ID_REG_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif

  localparam int                    IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] SPAN        = ADDR_WIDTH'(NUM_REGS * 4);
  localparam logic [IDX_W-1:0]      ID_IDX      = IDX_W'(NUM_REGS - 1);
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && (off < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return IDX_W'(off >> 2);
  endfunction

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  // Write channel state
  wstate_t                 wstate_q, wstate_d;
  logic                    aw_held_q, aw_held_d;
  logic                    w_held_q, w_held_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic [1:0]              bresp_q, bresp_d;
  logic [ID_WIDTH-1:0]     aw_id_q;
  logic [ADDR_WIDTH-1:0]   aw_addr_q;
  logic [7:0]              aw_len_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [DATA_WIDTH/8-1:0] w_strb_q;
  logic                    w_last_q;

  logic                    aw_fire, w_fire;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [7:0]              cur_len;
  logic [DATA_WIDTH-1:0]   cur_data;
  logic [DATA_WIDTH/8-1:0] cur_strb;
  logic                    cur_last;
  logic [IDX_W-1:0]        cur_idx;
  logic                    commit, wr_en;

  assign aw_fire = S_AXI_awvalid && awready_q;
  assign w_fire  = S_AXI_wvalid && wready_q;

  // Beats captured on an earlier edge come from the hold registers; same-edge beats bypass them.
  always_comb begin
    cur_addr  = aw_held_q ? aw_addr_q : S_AXI_awaddr;
    cur_len   = aw_held_q ? aw_len_q  : S_AXI_awlen;
    cur_data  = w_held_q  ? w_data_q  : S_AXI_wdata;
    cur_strb  = w_held_q  ? w_strb_q  : S_AXI_wstrb;
    cur_last  = w_held_q  ? w_last_q  : S_AXI_wlast;
    cur_idx   = addr_idx(cur_addr);
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    bresp_d   = bresp_q;
    commit    = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        aw_held_d = aw_held_q || aw_fire;
        w_held_d  = w_held_q || w_fire;
        if (aw_held_d && w_held_d) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          if ((cur_len == 8'd0) && cur_last) begin
            commit   = addr_hit(cur_addr);
            bresp_d  = addr_hit(cur_addr) ? RESP_OKAY : RESP_SLVERR;
            wstate_d = W_RESP;
          end else begin
            bresp_d  = RESP_SLVERR;
            wstate_d = cur_last ? W_RESP : W_DATA;
          end
        end
      end
      W_DATA: if (w_fire && S_AXI_wlast) wstate_d = W_RESP;
      W_RESP: if (S_AXI_bready) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
    awready_d = (wstate_d == W_IDLE) && !aw_held_d;
    wready_d  = ((wstate_d == W_IDLE) && !w_held_d) || (wstate_d == W_DATA);
  end

  // The ID register acknowledges writes with OKAY but never changes.
  assign wr_en = commit && !(ID_EN && (cur_idx == ID_IDX));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wstate_q  <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bresp_q   <= 2'b00;
      aw_id_q   <= '0;
    end else begin
      wstate_q  <= wstate_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bresp_q   <= bresp_d;
      if (aw_fire) aw_id_q <= S_AXI_awid;
    end
  end

  always_ff @(posedge ACLK) begin
    if (aw_fire) begin
      aw_addr_q <= S_AXI_awaddr;
      aw_len_q  <= S_AXI_awlen;
    end
    if (w_fire) begin
      w_data_q <= S_AXI_wdata;
      w_strb_q <= S_AXI_wstrb;
      w_last_q <= S_AXI_wlast;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < DATA_WIDTH/8; k++)
        if (cur_strb[k]) regs_q[cur_idx][8*k +: 8] <= cur_data[8*k +: 8];
    end
  end

  assign S_AXI_awready = awready_q;
  assign S_AXI_wready  = wready_q;
  assign S_AXI_bvalid  = (wstate_q == W_RESP);
  assign S_AXI_bresp   = bresp_q;
  assign S_AXI_bid     = aw_id_q;

  // Read channel state
  rstate_t               rstate_q, rstate_d;
  logic                  arready_q;
  logic                  rvalid_q;
  logic                  rlast_q;
  logic [1:0]            rresp_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [7:0]            rcnt_q;
  logic                  ar_fire, r_fire;
  logic                  ar_load, r_step, r_done;
  logic                  ar_ok;
  logic [IDX_W-1:0]      ar_idx;
  logic [DATA_WIDTH-1:0] ar_word;

  assign ar_fire = S_AXI_arvalid && arready_q;
  assign r_fire  = rvalid_q && S_AXI_rready;
  assign ar_idx  = addr_idx(S_AXI_araddr);
  assign ar_ok   = addr_hit(S_AXI_araddr) && (S_AXI_arlen == 8'd0);
  assign ar_word = (ID_EN && (ar_idx == ID_IDX)) ? ID_VALUE : regs_q[ar_idx];

  always_comb begin
    rstate_d = rstate_q;
    ar_load  = 1'b0;
    r_step   = 1'b0;
    r_done   = 1'b0;
    case (rstate_q)
      R_IDLE: if (ar_fire) begin
        ar_load  = 1'b1;
        rstate_d = R_DATA;
      end
      R_DATA: if (r_fire) begin
        if (rcnt_q == 8'd0) begin
          r_done   = 1'b1;
          rstate_d = R_IDLE;
        end else begin
          r_step = 1'b1;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Beat payload is registered on AR acceptance, so a same-edge write is not reflected.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= 2'b00;
      rid_q     <= '0;
      rdata_q   <= '0;
      rcnt_q    <= 8'd0;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= (rstate_d == R_IDLE);
      rvalid_q  <= (rstate_d == R_DATA);
      if (ar_load) begin
        rid_q   <= S_AXI_arid;
        rcnt_q  <= S_AXI_arlen;
        rlast_q <= (S_AXI_arlen == 8'd0);
        rdata_q <= ar_ok ? ar_word : '0;
        rresp_q <= ar_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (r_step) begin
        rcnt_q  <= rcnt_q - 8'd1;
        rlast_q <= (rcnt_q == 8'd1);
      end else if (r_done) begin
        rlast_q <= 1'b0;
      end
    end
  end

  assign S_AXI_arready = arready_q;
  assign S_AXI_rvalid  = rvalid_q;
  assign S_AXI_rlast   = rlast_q;
  assign S_AXI_rresp   = rresp_q;
  assign S_AXI_rid     = rid_q;
  assign S_AXI_rdata   = rdata_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_export
    if (ID_EN && (i == NUM_REGS - 1)) begin : g_id
      assign regs_o[32*i +: 32] = ID_VALUE;
    end else begin : g_rw
      assign regs_o[32*i +: 32] = regs_q[i];
    end
  end

  logic unused_sideband;
  assign unused_sideband = &{1'b0, S_AXI_awsize, S_AXI_awburst, S_AXI_awlock, S_AXI_awcache,
                             S_AXI_awprot, S_AXI_awqos, S_AXI_awregion, S_AXI_arsize,
                             S_AXI_arburst, S_AXI_arlock, S_AXI_arcache, S_AXI_arprot,
                             S_AXI_arqos, S_AXI_arregion};

endmodule

// File: tb/tb_axilite_regbank_slave.sv
// Scoreboard bench for axilite_regbank_slave: expected B/R responses are queued at issue time.
module tb_axilite_regbank_slave;

`ifdef AXIL_REGBANK_ID_REG_EN
  localparam bit TB_ID_EN = 1'b1;
`else
  localparam bit TB_ID_EN = 1'b0;
`endif

  localparam int          NREGS = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] IDV   = 32'hA5A5_0001;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  logic [3:0]  S_AXI_awid = '0, S_AXI_arid = '0, S_AXI_bid, S_AXI_rid;
  logic [31:0] S_AXI_awaddr = '0, S_AXI_araddr = '0, S_AXI_wdata = '0, S_AXI_rdata;
  logic [7:0]  S_AXI_awlen = '0, S_AXI_arlen = '0;
  logic [3:0]  S_AXI_wstrb = '0;
  logic        S_AXI_wlast = 1'b0;
  logic        S_AXI_awvalid = 1'b0, S_AXI_wvalid = 1'b0, S_AXI_arvalid = 1'b0;
  logic        S_AXI_bready = 1'b0, S_AXI_rready = 1'b0;
  logic        S_AXI_awready, S_AXI_wready, S_AXI_bvalid, S_AXI_arready, S_AXI_rvalid, S_AXI_rlast;
  logic [1:0]  S_AXI_bresp, S_AXI_rresp;
  logic [NREGS*32-1:0] regs_o;
  logic [2:0]  sb_size = '0, sb_prot = '0;
  logic [1:0]  sb_burst = 2'b01;
  logic        sb_lock = 1'b0;
  logic [3:0]  sb_cache = '0, sb_qos = '0, sb_region = '0;

  axilite_regbank_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_awid(S_AXI_awid), .S_AXI_awaddr(S_AXI_awaddr), .S_AXI_awlen(S_AXI_awlen),
    .S_AXI_awsize(sb_size), .S_AXI_awburst(sb_burst), .S_AXI_awlock(sb_lock),
    .S_AXI_awcache(sb_cache), .S_AXI_awprot(sb_prot), .S_AXI_awqos(sb_qos),
    .S_AXI_awregion(sb_region), .S_AXI_awvalid(S_AXI_awvalid), .S_AXI_awready(S_AXI_awready),
    .S_AXI_wdata(S_AXI_wdata), .S_AXI_wstrb(S_AXI_wstrb), .S_AXI_wlast(S_AXI_wlast),
    .S_AXI_wvalid(S_AXI_wvalid), .S_AXI_wready(S_AXI_wready),
    .S_AXI_bid(S_AXI_bid), .S_AXI_bresp(S_AXI_bresp), .S_AXI_bvalid(S_AXI_bvalid),
    .S_AXI_bready(S_AXI_bready),
    .S_AXI_arid(S_AXI_arid), .S_AXI_araddr(S_AXI_araddr), .S_AXI_arlen(S_AXI_arlen),
    .S_AXI_arsize(sb_size), .S_AXI_arburst(sb_burst), .S_AXI_arlock(sb_lock),
    .S_AXI_arcache(sb_cache), .S_AXI_arprot(sb_prot), .S_AXI_arqos(sb_qos),
    .S_AXI_arregion(sb_region), .S_AXI_arvalid(S_AXI_arvalid), .S_AXI_arready(S_AXI_arready),
    .S_AXI_rid(S_AXI_rid), .S_AXI_rdata(S_AXI_rdata), .S_AXI_rresp(S_AXI_rresp),
    .S_AXI_rlast(S_AXI_rlast), .S_AXI_rvalid(S_AXI_rvalid), .S_AXI_rready(S_AXI_rready),
    .regs_o(regs_o)
  );

  typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t      b_q[$];
  r_exp_t      r_q[$];
  logic [31:0] m_regs [NREGS];
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic bit m_hit(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'(NREGS * 4));
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] m_word(input int i);
    return (TB_ID_EN && i == NREGS - 1) ? IDV : m_regs[i];
  endfunction

  function automatic logic [511:0] m_vec();
    logic [511:0] v = '0;
    for (int i = 0; i < NREGS; i++) v[32*i +: 32] = m_word(i);
    return v;
  endfunction

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    bit got = 1'b0;
    S_AXI_awid = id; S_AXI_awaddr = addr; S_AXI_awlen = len; S_AXI_awvalid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (S_AXI_awready) begin got = 1'b1; @(negedge ACLK); break; end
      @(negedge ACLK);
    end
    S_AXI_awvalid = 1'b0;
    if (!got) chk("aw_timeout", 0, 1);
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input int beats);
    for (int b = 0; b < beats; b++) begin
      bit got = 1'b0;
      S_AXI_wdata = (b == 0) ? data : ~data; S_AXI_wstrb = strb;
      S_AXI_wlast = (b == beats - 1); S_AXI_wvalid = 1'b1;
      for (int k = 0; k < 200; k++) begin
        if (S_AXI_wready) begin got = 1'b1; @(negedge ACLK); break; end
        @(negedge ACLK);
      end
      if (!got) chk("w_timeout", 0, 1);
    end
    S_AXI_wvalid = 1'b0; S_AXI_wlast = 1'b0;
  endtask

  // Queue the expected B response, update the model, then drive AW/W (W leads by 'lead' cycles).
  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [31:0] data, input logic [3:0] strb, input int lead);
    b_exp_t e;
    e.id = id;
    e.resp = (m_hit(addr) && len == 8'd0) ? 2'b00 : 2'b10;
    b_q.push_back(e);
    if (m_hit(addr) && len == 8'd0 && !(TB_ID_EN && m_idx(addr) == NREGS - 1))
      for (int k = 0; k < 4; k++)
        if (strb[k]) m_regs[m_idx(addr)][8*k +: 8] = data[8*k +: 8];
    fork
      w_send(data, strb, int'(len) + 1);
      begin repeat (lead) @(negedge ACLK); aw_send(id, addr, len); end
    join
    chk("bvalid_lat", S_AXI_bvalid, 1);
  endtask

  task automatic axi_read_issue(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    bit got = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      r_exp_t e;
      e.id = id;
      e.data = (m_hit(addr) && len == 8'd0) ? m_word(m_idx(addr)) : 32'h0;
      e.resp = (m_hit(addr) && len == 8'd0) ? 2'b00 : 2'b10;
      e.last = (b == int'(len));
      r_q.push_back(e);
    end
    S_AXI_arid = id; S_AXI_araddr = addr; S_AXI_arlen = len; S_AXI_arvalid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (S_AXI_arready) begin got = 1'b1; @(negedge ACLK); break; end
      @(negedge ACLK);
    end
    S_AXI_arvalid = 1'b0;
    if (!got) chk("ar_timeout", 0, 1);
    chk("rvalid_lat", S_AXI_rvalid, 1);
  endtask

  task automatic b_collect();
    b_exp_t e;
    bit got = 1'b0;
    S_AXI_bready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (S_AXI_bvalid) begin got = 1'b1; break; end
      @(negedge ACLK);
    end
    if (!got) chk("b_timeout", 0, 1);
    else if (b_q.size() == 0) chk("b_unexpected", 1, 0);
    else begin
      e = b_q.pop_front();
      chk("bid", S_AXI_bid, e.id);
      chk("bresp", S_AXI_bresp, e.resp);
      @(negedge ACLK);
      chk("bvalid_drop", S_AXI_bvalid, 0);
    end
    S_AXI_bready = 1'b0;
  endtask

  task automatic r_collect();
    r_exp_t e;
    S_AXI_rready = 1'b1;
    while (r_q.size() > 0) begin
      bit got = 1'b0;
      for (int k = 0; k < 200; k++) begin
        if (S_AXI_rvalid) begin got = 1'b1; break; end
        @(negedge ACLK);
      end
      e = r_q.pop_front();
      if (!got) chk("r_timeout", 0, 1);
      else begin
        chk("rbeat", {S_AXI_rid, S_AXI_rdata, S_AXI_rresp, S_AXI_rlast},
                     {e.id, e.data, e.resp, e.last});
        @(negedge ACLK);
      end
    end
    chk("rvalid_drop", S_AXI_rvalid, 0);
    S_AXI_rready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    repeat (3) @(negedge ACLK);
    chk("reset_outs", {S_AXI_awready, S_AXI_wready, S_AXI_bvalid, S_AXI_bid, S_AXI_bresp,
                       S_AXI_arready, S_AXI_rvalid, S_AXI_rid, S_AXI_rdata, S_AXI_rresp,
                       S_AXI_rlast}, 0);
    chk("reset_regs", regs_o, m_vec());
    ARESET = 1'b0;
    repeat (2) @(negedge ACLK);
    chk("idle_ready", {S_AXI_awready, S_AXI_wready, S_AXI_arready}, 3'b111);

    // Full write then read back
    axi_write(4'd3, 32'h1004, 8'd0, 32'hCAFE_BABE, 4'hF, 0);
    b_collect();
    chk("regs_full", regs_o[63:32], 32'hCAFE_BABE);
    axi_read_issue(4'd2, 32'h1004, 8'd0);
    r_collect();

    // W leads AW by two cycles, partial strobe
    axi_write(4'd9, 32'h1004, 8'd0, 32'h1122_3344, 4'b0101, 2);
    b_collect();
    chk("regs_partial", regs_o[63:32], 32'hCA22_BA44);
    axi_read_issue(4'd1, 32'h1004, 8'd0);
    r_collect();

    // Out-of-range accesses on both sides of the window
    axi_write(4'd4, 32'h2000, 8'd0, 32'hDEAD_BEEF, 4'hF, 0);
    b_collect();
    chk("regs_miss", regs_o, m_vec());
    axi_read_issue(4'd5, 32'h0FFC, 8'd0);
    r_collect();
    axi_write(4'd6, 32'h103F, 8'd0, 32'h0BAD_F00D, 4'hF, 0);
    b_collect();
    chk("regs_lastreg", regs_o, m_vec());

    // Multi-beat accesses
    axi_read_issue(4'd7, 32'h1000, 8'd3);
    r_collect();
    axi_write(4'd8, 32'h1008, 8'd1, 32'h7777_7777, 4'hF, 0);
    b_collect();
    chk("regs_burst", regs_o, m_vec());

    // Concurrent write and read with both response channels stalled
    fork
      axi_write(4'd5, 32'h1008, 8'd0, 32'h5A5A_0F0F, 4'hF, 0);
      axi_read_issue(4'd6, 32'h1004, 8'd0);
    join
    for (int c = 0; c < 5; c++) begin
      chk("stall_b", {S_AXI_bvalid, S_AXI_bid, S_AXI_bresp}, {1'b1, b_q[0].id, b_q[0].resp});
      chk("stall_r", {S_AXI_rvalid, S_AXI_rid, S_AXI_rdata, S_AXI_rresp, S_AXI_rlast},
                     {1'b1, r_q[0].id, r_q[0].data, r_q[0].resp, r_q[0].last});
      @(negedge ACLK);
    end
    b_collect();
    r_collect();
    chk("regs_concurrent", regs_o, m_vec());

`ifdef AXIL_REGBANK_ID_REG_EN
    axi_write(4'd2, 32'h103C, 8'd0, 32'h0, 4'hF, 0);
    b_collect();
    axi_read_issue(4'd3, 32'h103C, 8'd0);
    r_collect();
    chk("regs_id", regs_o[511:480], 32'hA5A5_0001);
`endif

    // Reset in the middle of a read burst
    axi_read_issue(4'd7, 32'h1000, 8'd3);
    repeat (2) @(negedge ACLK);
    ARESET = 1'b1;
    #1;
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    r_q.delete();
    chk("midreset_outs", {S_AXI_awready, S_AXI_wready, S_AXI_bvalid, S_AXI_bid, S_AXI_bresp,
                          S_AXI_arready, S_AXI_rvalid, S_AXI_rid, S_AXI_rdata, S_AXI_rresp,
                          S_AXI_rlast}, 0);
    chk("midreset_regs", regs_o, m_vec());
    @(negedge ACLK);
    ARESET = 1'b0;
    repeat (2) @(negedge ACLK);
    axi_read_issue(4'd1, 32'h1004, 8'd0);
    r_collect();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
